// File: rtl/bus_arbiter_rr_bcast_if.sv
// Shared-bus bundle: driver FIFO heads on one side, receiver ports on the other.
interface bus_arbiter_rr_bcast_if #(
  parameter int DRVRS   = 8,
  parameter int PCKG_SZ = 16
);
  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         full;
  logic [DRVRS-1:0]         push;
  logic [DRVRS*PCKG_SZ-1:0] D_push;

  modport master (input pndng, D_pop, full, output pop, push, D_push);
  modport slave  (output pndng, D_pop, full, input pop, push, D_push);
endinterface

// File: rtl/bus_arbiter_rr_bcast.sv
// Shared-bus arbiter: moves one packet per transaction from a pending driver to its
// destination receiver (or all other receivers on broadcast), with drop and counters.
module bus_arbiter_rr_bcast #(
  parameter int         DRVRS     = 8,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF,
  parameter int         CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  bus_arbiter_rr_bcast_if.master bus,
  output logic                   busy,
  output logic [7:0]             grant_id,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);
  localparam int IDX_W = $clog2(DRVRS);

  typedef enum logic [1:0] {IDLE, GRANT, DELIVER, DROP} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]         last_grant;
  logic [IDX_W-1:0]         grant_idx;
  logic [7:0]               winner;
  logic                     found;
  logic [5:0]               rr_pos;
  logic [PCKG_SZ-1:0]       d_pop_arr [DRVRS];
  logic [PCKG_SZ-1:0]       d_push_q  [DRVRS];
  logic [PCKG_SZ-1:0]       head;
  logic [PCKG_SZ-1:0]       pkt_q;
  logic [7:0]               head_dest;
  logic                     head_valid;
  logic [DRVRS-1:0]         mask_nxt;
  logic [DRVRS-1:0]         push_mask;
  logic [DRVRS-1:0]         pop_vec;
  logic [DRVRS-1:0]         push_vec;
  logic [DRVRS*PCKG_SZ-1:0] d_push_vec;

  assign grant_idx = grant_id[IDX_W-1:0];

  always_comb begin
    for (int i = 0; i < DRVRS; i++) d_pop_arr[i] = bus.D_pop[i*PCKG_SZ +: PCKG_SZ];
  end

  // Both searches walk from the far end so the preferred pending driver is written last.
  always_comb begin
    found  = |bus.pndng;
    winner = '0;
    rr_pos = '0;
    if (mode) begin
      for (int i = DRVRS-1; i >= 0; i--)
        if (bus.pndng[i]) winner = 8'(i);
    end else begin
      for (int k = DRVRS; k >= 1; k--) begin
        rr_pos = 6'(last_grant) + 6'(k);
        if (rr_pos >= 6'(DRVRS)) rr_pos = rr_pos - 6'(DRVRS);
        if (bus.pndng[rr_pos[IDX_W-1:0]]) winner = 8'(rr_pos);
      end
    end
  end

  // The receiver set is captured as a mask, so unicast and broadcast share one delivery path.
  always_comb begin
    head       = d_pop_arr[grant_idx];
    head_dest  = head[PCKG_SZ-1 -: 8];
    head_valid = 1'b1;
    mask_nxt   = '0;
    if (head_dest == BROADCAST) begin
      mask_nxt            = '1;
      mask_nxt[grant_idx] = 1'b0;
    end else if (head_dest < 8'(DRVRS)) begin
      mask_nxt[head_dest[IDX_W-1:0]] = 1'b1;
    end else begin
      head_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop_vec   = '0;
    push_vec  = '0;
    case (state)
      IDLE: begin
        if (found) state_nxt = GRANT;
      end
      GRANT: begin
        pop_vec[grant_idx] = 1'b1;
        state_nxt          = head_valid ? DELIVER : DROP;
      end
      DELIVER: begin
        if ((bus.full & push_mask) == '0) begin
          push_vec  = push_mask;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_id   <= '0;
      last_grant <= IDX_W'(DRVRS-1);
      pkt_q      <= '0;
      push_mask  <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      for (int j = 0; j < DRVRS; j++) d_push_q[j] <= '0;
    end else begin
      if (state == IDLE && found) grant_id <= winner;
      if (state == GRANT) begin
        last_grant <= grant_idx;
        pkt_q      <= head;
        push_mask  <= mask_nxt;
      end
      if (push_vec != '0) begin
        for (int j = 0; j < DRVRS; j++)
          if (push_vec[j]) d_push_q[j] <= pkt_q;
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
      if (state == DROP && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Pushed slices show the packet in the push cycle itself; the rest hold their last value.
  always_comb begin
    d_push_vec = '0;
    for (int j = 0; j < DRVRS; j++)
      d_push_vec[j*PCKG_SZ +: PCKG_SZ] = push_vec[j] ? pkt_q : d_push_q[j];
  end

  assign bus.pop    = pop_vec;
  assign bus.push   = push_vec;
  assign bus.D_push = d_push_vec;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_bus_arbiter_rr_bcast.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized run scored against a transaction-level reference model.
module tb_bus_arbiter_rr_bcast;
  localparam int N     = 8;
  localparam int PW    = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int DW    = N*PW;

  logic             clk = 1'b0;
  logic             reset;
  logic             mode;
  logic             busy;
  logic [7:0]       grant_id;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_pkt, exp_drop, mdl_last;
  logic [PW-1:0] mdl_dpush [N];
  logic [PW-1:0] dpop_tb [N];

  typedef struct {
    int           src;
    logic [PW-1:0] data;
    logic [N-1:0] exp_pop;
    logic [N-1:0] exp_push;
  } vec_t;
  vec_t vecs [8];

  bus_arbiter_rr_bcast_if #(.DRVRS(N), .PCKG_SZ(PW)) bus ();

  bus_arbiter_rr_bcast #(
    .DRVRS(N), .PCKG_SZ(PW), .BROADCAST(8'hFF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .bus(bus),
    .busy(busy), .grant_id(grant_id), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic m, input logic [N-1:0] fl);
    bus.pndng = req;
    mode      = m;
    bus.full  = fl;
  endtask

  task automatic setDpop(input int j, input logic [PW-1:0] v);
    dpop_tb[j]               = v;
    bus.D_pop[j*PW +: PW]    = v;
  endtask

  function automatic int satInc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [DW-1:0] packModel();
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*PW +: PW] = mdl_dpush[j];
    return r;
  endfunction

  function automatic int pickWinner(input logic [N-1:0] req, input logic fp, input int last);
    if (fp) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] destMask(input logic [PW-1:0] pkt, input int src);
    logic [N-1:0] one;
    int d;
    one = 1;
    d   = int'(pkt[PW-1 -: 8]);
    if (d == 255) return ~(one << src);
    if (d < N)    return one << d;
    return '0;
  endfunction

  function automatic logic [PW-1:0] randPacket();
    int sel;
    logic [7:0] d;
    sel = $urandom_range(0, 9);
    if (sel < 6)       d = 8'($urandom_range(0, N-1));
    else if (sel < 8)  d = 8'hFF;
    else if (sel == 8) d = 8'($urandom_range(N, 254));
    else               d = 8'($urandom);
    return {d, 8'($urandom)};
  endfunction

  task automatic modelReset();
    exp_pkt  = 0;
    exp_drop = 0;
    mdl_last = N-1;
    for (int j = 0; j < N; j++) mdl_dpush[j] = '0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pop"},      DW'(bus.pop),  '0);
    checkOutput({tag, "_push"},     DW'(bus.push), '0);
    checkOutput({tag, "_d_push"},   bus.D_push,    '0);
    checkOutput({tag, "_busy"},     DW'(busy),     '0);
    checkOutput({tag, "_grant_id"}, DW'(grant_id), '0);
    checkOutput({tag, "_pkt_cnt"},  DW'(pkt_cnt),  '0);
    checkOutput({tag, "_drop_cnt"}, DW'(drop_cnt), '0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus('0, 1'b0, '0);
    tick();
    tick();
    reset = 1'b1;
    modelReset();
  endtask

  // One single-requester transaction starting from IDLE, with optional receiver stall.
  task automatic txn(input string tag, input int src, input logic [PW-1:0] data,
                     input logic [N-1:0] exp_pop, input logic [N-1:0] hold_full,
                     input int hold_cycles, input logic [N-1:0] rel_full,
                     input logic [N-1:0] exp_push);
    logic [N-1:0] one;
    one = 1;
    setDpop(src, data);
    applyStimulus(one << src, 1'b0, hold_full);
    tick();
    applyStimulus('0, 1'b0, hold_full);
    settle();
    checkOutput({tag, "_pop"},   DW'(bus.pop),  DW'(exp_pop));
    checkOutput({tag, "_grant"}, DW'(grant_id), DW'(src));
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      settle();
      checkOutput({tag, "_push_stalled"}, DW'(bus.push), '0);
      checkOutput({tag, "_busy_stalled"}, DW'(busy),     DW'(1));
    end
    tick();
    bus.full = rel_full;
    settle();
    checkOutput({tag, "_push"}, DW'(bus.push), DW'(exp_push));
    checkOutput({tag, "_pop_off"}, DW'(bus.pop), '0);
    if (exp_push != '0) begin
      for (int j = 0; j < N; j++) if (exp_push[j]) mdl_dpush[j] = data;
      exp_pkt = satInc(exp_pkt);
    end else begin
      exp_drop = satInc(exp_drop);
    end
    checkOutput({tag, "_d_push"}, bus.D_push, packModel());
    tick();
    bus.full = '0;
    settle();
    checkOutput({tag, "_busy_idle"}, DW'(busy),     '0);
    checkOutput({tag, "_pkt_cnt"},   DW'(pkt_cnt),  DW'(exp_pkt));
    checkOutput({tag, "_drop_cnt"},  DW'(drop_cnt), DW'(exp_drop));
    checkOutput({tag, "_d_hold"},    bus.D_push,    packModel());
  endtask

  task automatic waitPop(output int cycles);
    cycles = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      settle();
      if (bus.pop != '0) begin
        cycles = c;
        break;
      end
    end
    if (cycles == 0) checkOutput("pop_timeout", DW'(bus.pop), DW'(1));
  endtask

  initial begin
    logic [N-1:0] one;
    int cyc;
    one   = 1;
    reset = 1'b0;
    applyStimulus('0, 1'b0, '0);
    for (int j = 0; j < N; j++) setDpop(j, '0);

    vecs[0] = '{src: 1, data: 16'h0208, exp_pop: 8'h02, exp_push: 8'h04};
    vecs[1] = '{src: 3, data: 16'hFF55, exp_pop: 8'h08, exp_push: 8'hF7};
    vecs[2] = '{src: 5, data: 16'h2011, exp_pop: 8'h20, exp_push: 8'h00};
    vecs[3] = '{src: 4, data: 16'h0499, exp_pop: 8'h10, exp_push: 8'h10};
    vecs[4] = '{src: 0, data: 16'h0700, exp_pop: 8'h01, exp_push: 8'h80};
    vecs[5] = '{src: 7, data: 16'h08AA, exp_pop: 8'h80, exp_push: 8'h00};
    vecs[6] = '{src: 0, data: 16'hFF01, exp_pop: 8'h01, exp_push: 8'hFE};
    vecs[7] = '{src: 7, data: 16'hFE3C, exp_pop: 8'h80, exp_push: 8'h00};

    doReset();
    settle();
    checkResetState("reset");

    for (int v = 0; v < 8; v++)
      txn($sformatf("vec%0d", v), vecs[v].src, vecs[v].data, vecs[v].exp_pop,
          '0, 0, '0, vecs[v].exp_push);

    // Unicast stall, broadcast ignoring the source's own full, broadcast stall.
    txn("bp_uni",   2, 16'h0533, 8'h04, 8'h20, 10, 8'hDF, 8'h20);
    txn("bp_bc_src", 3, 16'hFF77, 8'h08, 8'h08, 0,  8'h08, 8'hF7);
    txn("bp_bc",    6, 16'hFF12, 8'h40, 8'h01, 3,  8'h40, 8'hBF);

    // Reset while a unicast is stalled in delivery: packet is lost.
    setDpop(4, 16'h0566);
    applyStimulus(8'h10, 1'b0, 8'h20);
    tick();
    applyStimulus('0, 1'b0, 8'h20);
    settle();
    checkOutput("rst_mid_pop", DW'(bus.pop), DW'(8'h10));
    tick();
    settle();
    checkOutput("rst_mid_stall", DW'(bus.push), '0);
    reset = 1'b0;
    tick();
    settle();
    checkResetState("rst_mid");
    modelReset();
    reset = 1'b1;

    // Round-robin fairness with everyone pending, then fixed priority.
    for (int j = 0; j < N; j++) setDpop(j, {8'(j), 8'(j)});
    applyStimulus('1, 1'b0, '0);
    for (int t = 0; t < 9; t++) begin
      waitPop(cyc);
      checkOutput("rr_pop",   DW'(bus.pop), DW'(one << (t % N)));
      checkOutput("rr_cycles", DW'(cyc),    DW'((t == 0) ? 1 : 3));
    end
    mode = 1'b1;
    for (int t = 0; t < 3; t++) begin
      waitPop(cyc);
      checkOutput("fp_pop",    DW'(bus.pop), DW'(8'h01));
      checkOutput("fp_cycles", DW'(cyc),     DW'(3));
    end
    bus.pndng = 8'hA0;
    waitPop(cyc);
    checkOutput("fp_pop_hi", DW'(bus.pop), DW'(8'h20));
    bus.pndng = '0;
    tick();
    tick();
    settle();
    checkOutput("after_rst_pkt_cnt", DW'(pkt_cnt), DW'(13));

    // Randomized traffic against the transaction-level model.
    doReset();
    for (int t = 0; t < 150; t++) begin
      logic [N-1:0] req, fl, mask, expp;
      logic m;
      int w;
      bit done;
      for (int j = 0; j < N; j++) setDpop(j, randPacket());
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      m   = 1'($urandom);
      applyStimulus(req, m, N'($urandom));
      settle();
      checkOutput("rnd_idle_busy", DW'(busy),     '0);
      checkOutput("rnd_idle_pop",  DW'(bus.pop),  '0);
      checkOutput("rnd_idle_push", DW'(bus.push), '0);
      checkOutput("rnd_pkt_cnt",   DW'(pkt_cnt),  DW'(exp_pkt));
      checkOutput("rnd_drop_cnt",  DW'(drop_cnt), DW'(exp_drop));
      checkOutput("rnd_d_hold",    bus.D_push,    packModel());
      if (req == '0) begin
        tick();
        continue;
      end
      w = pickWinner(req, m, mdl_last);
      tick();
      for (int j = 0; j < N; j++) setDpop(j, randPacket());
      applyStimulus(N'($urandom), 1'($urandom), N'($urandom));
      settle();
      checkOutput("rnd_pop",   DW'(bus.pop),  DW'(one << w));
      checkOutput("rnd_grant", DW'(grant_id), DW'(w));
      checkOutput("rnd_grant_push", DW'(bus.push), '0);
      mask     = destMask(dpop_tb[w], w);
      mdl_last = w;
      if (mask == '0) begin
        tick();
        settle();
        checkOutput("rnd_drop_push", DW'(bus.push), '0);
        checkOutput("rnd_drop_busy", DW'(busy),     DW'(1));
        exp_drop = satInc(exp_drop);
        tick();
        continue;
      end
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        tick();
        fl = (c >= 12) ? '0 : (N'($urandom) & N'($urandom) & N'($urandom));
        applyStimulus(N'($urandom), 1'($urandom), fl);
        settle();
        expp = ((fl & mask) == '0) ? mask : '0;
        checkOutput("rnd_push",    DW'(bus.push), DW'(expp));
        checkOutput("rnd_pop_off", DW'(bus.pop),  '0);
        if (expp != '0) begin
          for (int j = 0; j < N; j++) if (mask[j]) mdl_dpush[j] = dpop_tb[w];
          exp_pkt = satInc(exp_pkt);
          checkOutput("rnd_d_push", bus.D_push, packModel());
          done = 1'b1;
        end
      end
      tick();
    end
    applyStimulus('0, 1'b0, '0);
    settle();
    checkOutput("rnd_final_pkt_cnt",  DW'(pkt_cnt),  DW'(exp_pkt));
    checkOutput("rnd_final_drop_cnt", DW'(drop_cnt), DW'(exp_drop));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
